// File: rtl/mod_n_counter_pkg.sv
// Shared constants and types for the modulo-N up/down counter.
// Optional one-shot build: define COUNTER_ONESHOT_EN.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } os_state_t;

endpackage

// File: rtl/mod_n_counter_if.sv
// Control/data bundle between a counter and whoever drives it.
// COUNTER_ONESHOT_EN adds ONESHOT and DONE.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
);
    logic             LD;
    logic             CTP;
    logic             CTT;
    logic             UP;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             Co;
`ifdef COUNTER_ONESHOT_EN
    logic             ONESHOT;
    logic             DONE;
`endif

    modport master (
        output LD, CTP, CTT, UP, D,
`ifdef COUNTER_ONESHOT_EN
        output ONESHOT,
        input  DONE,
`endif
        input  Q, Co
    );

    modport slave (
        input  LD, CTP, CTT, UP, D,
`ifdef COUNTER_ONESHOT_EN
        input  ONESHOT,
        output DONE,
`endif
        output Q, Co
    );

endinterface

// File: rtl/mod_n_counter_next.sv
// Next-value and terminal-state logic for a modulo-N counter.
// Arithmetic is one bit wider so MODULUS = 2**WIDTH wraps cleanly.
module mod_n_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             term
);

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] q_ext;

    assign q_ext = {1'b0, q};

    always_comb begin
        term = 1'b0;
        nxt  = '0;
        if (up == DIR_UP) begin
            term = (q_ext == MAXV);
            nxt  = term ? '0 : WIDTH'(q_ext + 1'b1);
        end else begin
            term = (q_ext == '0);
            nxt  = term ? WIDTH'(MAXV)
                        : WIDTH'(q_ext - 1'b1);
        end
    end

endmodule

// File: rtl/mod_n_counter.sv
// Cascadable modulo-N up/down counter with saturating load.
// Defining COUNTER_ONESHOT_EN adds a RUN/HALT one-shot mode.
module mod_n_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic            CP,
    input  logic            CR,
    mod_n_counter_if.slave  bus
);

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] d_sat;
    logic             term;
    logic             cnt_en;

    mod_n_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q    (q),
        .up   (bus.UP),
        .nxt  (nxt),
        .term (term)
    );

    assign d_sat = ({1'b0, bus.D} > MAXV) ? WIDTH'(MAXV)
                                           : bus.D;

`ifdef COUNTER_ONESHOT_EN
    os_state_t state;
    os_state_t state_nxt;
    logic      done;
    logic      done_nxt;
    logic      halt;

    assign halt = (state == HALT);

    always_ff @(posedge CP) begin
        if (CR) begin
            state <= RUN;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = done;
        unique case (state)
            RUN: begin
                if (bus.LD && bus.CTP && bus.CTT &&
                    term && bus.ONESHOT) begin
                    state_nxt = HALT;
                    done_nxt  = 1'b1;
                end
            end
            HALT: begin
                if (!bus.LD) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = RUN;
                done_nxt  = 1'b0;
            end
        endcase
    end

    assign cnt_en   = bus.CTP & bus.CTT & ~halt;
    assign bus.Co   = bus.CTT & term & ~halt;
    assign bus.DONE = done;
`else
    assign cnt_en = bus.CTP & bus.CTT;
    assign bus.Co = bus.CTT & term;
`endif

    always_ff @(posedge CP) begin
        if (CR) begin
            q <= '0;
        end else if (!bus.LD) begin
            q <= d_sat;
        end else if (cnt_en) begin
            q <= nxt;
        end
    end

    assign bus.Q = q;

endmodule
